// File: rtl/data_register_file.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, two combinational
// read ports, a zero-fill sequencer after reset or on request, and an optional write bypass.
module data_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_data,
  input  logic [ADDR_WIDTH-1:0] load_data_address,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  clear,
  output logic                  busy,
  output logic                  load_dropped
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] IDLE = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  accept;

  // Clear has priority over a same-cycle write, so a write is only taken in IDLE without clear.
  assign accept = load_data && (state == IDLE) && !clear;
  assign busy   = (state == INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      clr_ptr      <= '0;
      load_dropped <= 1'b0;
    end else begin
      load_dropped <= load_data && !accept;
      case (state)
        INIT: begin
          if (clr_ptr == LAST) begin
            state   <= IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          if (clear) state <= INIT;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; the sequencer zero-fills it instead.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (accept) begin
      mem[load_data_address] <= data_input;
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!busy) begin
      rd_data_a = mem[rd_addr_a];
      rd_data_b = mem[rd_addr_b];
      if (BYPASS != 0 && accept) begin
        if (load_data_address == rd_addr_a) rd_data_a = data_input;
        if (load_data_address == rd_addr_b) rd_data_b = data_input;
      end
    end
  end

endmodule

// File: doc/data_register_file.md
Name: data_register_file

Overview:
Parametrised successor to the single-port data register store. Provides a DEPTH x DATA_WIDTH array with one synchronous write port and two combinational read ports, so the CPU datapath can fetch two operands per cycle. Adds a hardware clear sequencer that runs after reset and on request, since the storage array itself is not reset. Adds an optional write-to-read bypass. Sits between the operand-fetch stage and the load path of the CPU.

Parameters:
DATA_WIDTH, 16, bit width of each entry
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries
BYPASS, 0, 1 = a read whose address equals an accepted same-cycle write returns data_input

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
load_data  in  1  write request
load_data_address  in  ADDR_WIDTH  write address
data_input  in  DATA_WIDTH  write data
rd_addr_a  in  ADDR_WIDTH  read port A address
rd_data_a  out  DATA_WIDTH  read port A data
rd_addr_b  in  ADDR_WIDTH  read port B address
rd_data_b  out  DATA_WIDTH  read port B data
clear  in  1  request a full zero-fill of the array
busy  out  1  clear sequencer active; writes are not accepted
load_dropped  out  1  one-cycle pulse: a write request was rejected

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=INIT, clr_ptr=0, busy=1, load_dropped=0. Array contents are undefined. rd_data_a and rd_data_b read as 0 while busy=1.
- FSM states: INIT and IDLE.
- INIT, each cycle:
  - writes 0 to entry clr_ptr; clr_ptr increments.
  - when clr_ptr == DEPTH-1 the final zero is written, then next state=IDLE, busy=0, clr_ptr=0.
  - INIT lasts exactly DEPTH cycles after rst_n deasserts.
  - clear asserted during INIT is ignored; the sequence does not restart.
- IDLE:
  - clear=1: next state=INIT, busy=1 from the next edge. Any same-cycle load_data is dropped (clear wins).
  - load_data=1 and clear=0: memory[load_data_address] <= data_input at the edge. Write latency 1 cycle.
- Accepted-write definition: an accepted write is load_data=1 with FSM=IDLE and clear=0.
- Dropped writes: load_data=1 while not accepted (busy=1, or clear=1) sets load_dropped=1 for the following cycle only. The array is unchanged. Back-to-back drops hold load_dropped high continuously.
- Reads: combinational. rd_data_x = memory[rd_addr_x] when busy=0; 0 when busy=1.
  - Both ports may use the same address.
  - No read-side latency.
- Bypass:
  - BYPASS=1: an accepted write with load_data_address == rd_addr_x drives rd_data_x = data_input in the same cycle. Applies per port independently.
  - BYPASS=0: the read returns the old contents until the edge.
- Reset asserted mid-INIT or mid-operation: returns immediately to INIT with clr_ptr=0. The clear sequence restarts from entry 0 after rst_n rises.
- Address wrap: clr_ptr is ADDR_WIDTH+1 bits or is compared explicitly; no out-of-range access is possible.
- No X may propagate to the outputs after the first INIT completes.

Test Plan:
1. Release rst_n, hold all inputs low -> busy=1 for exactly 16 cycles, then 0. Reading all 16 addresses on A and B -> 0x0000.
2. After init, write 0xBEEF to addr 3 and 0x1234 to addr 15 -> next cycle rd_addr_a=3 gives 0xBEEF and rd_addr_b=15 gives 0x1234. Both ports at addr 3 -> both 0xBEEF.
3. BYPASS=1: write 0xA5A5 to addr 7 with rd_addr_a=7 in the same cycle -> rd_data_a=0xA5A5 that cycle. BYPASS=0 in the same case -> old value that cycle, 0xA5A5 next cycle.
4. load_data=1 during INIT, and load_data with clear=1 in IDLE -> load_dropped pulses one cycle, target entry unchanged. clear -> busy=1 for 16 cycles and all entries read back 0x0000.
5. Pull rst_n low at cycle 8 of INIT -> busy stays 1 and outputs read 0. After release, busy=1 for a full 16 cycles.
6. DATA_WIDTH=32, ADDR_WIDTH=6 -> init takes 64 cycles. Write and read back 0xDEADBEEF at addr 63 and addr 0.
